reg_dest_bank: RTL and testbench

Write-side counterpart of the 10-way 9-bit register-select multiplexer: decodes a 4-bit destination code and latches a 9-bit bus value into one of ten registers whose outputs feed the select mux inputs `a0`..`a9`. Provides per-register written flags, a one-cycle write acknowledge, sticky illegal-destination detection and a bank-wide synchronous clear. Sits between the processor's result bus and the operand-select mux.

---
 rtl/reg_dest_bank_pkg.sv | 14 +
 rtl/reg_dest_bank_dest_decoder.sv | 35 +++
 rtl/reg_dest_bank.sv | 121 ++++++++++++
 tb/tb_reg_dest_bank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dest_bank_pkg.sv
// rtl/reg_dest_bank_pkg.sv - shared constants and destination-code type for the register bank and select mux
//
// Purpose: one place for the bank geometry so the write-side bank and the
// read-side select mux always agree on width, depth and code size.
// Contents: DATA_W, NUM_REGS, SEL_W constants; reg_sel_t destination code.
package reg_dest_bank_pkg;

  localparam int DATA_W   = 9;
  localparam int NUM_REGS = 10;
  localparam int SEL_W    = 4;

  typedef logic [SEL_W-1:0] reg_sel_t;

endpackage

// File: rtl/reg_dest_bank_dest_decoder.sv
// rtl/reg_dest_bank_dest_decoder.sv - destination code to one-hot register enable decoder
//
// Purpose: turns a destination code into one-hot write enables for the bank
// and flags codes that do not name a register.
// Ports:
//   en      in   1         request qualifier; when low all outputs are 0
//   code    in   SEL_W     destination register code
//   onehot  out  NUM_REGS  bit i set when en and code == i
//   illegal out  1         en and code >= NUM_REGS
module dest_decoder
  import reg_dest_bank_pkg::*;
#(
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int SEL_W_P    = SEL_W
) (
  input  logic                  en,
  input  logic [SEL_W_P-1:0]    code,
  output logic [NUM_REGS_P-1:0] onehot,
  output logic                  illegal
);

  // Outputs are forced to zero under !en first, so an unknown code while idle
  // never reaches the enables or the error flag.
  always_comb begin
    onehot  = '0;
    illegal = 1'b0;
    if (en) begin
      for (int i = 0; i < NUM_REGS_P; i++) begin
        if (code == SEL_W_P'(i)) onehot[i] = 1'b1;
      end
      illegal = (32'(code) >= NUM_REGS_P);
    end
  end

endmodule

// File: rtl/reg_dest_bank.sv
// rtl/reg_dest_bank.sv - ten-entry destination register bank feeding the operand-select mux
//
// Purpose: latches the result bus into the register named by dest, tracks
// which registers have been written, acknowledges accepted writes for one
// cycle and records requests to non-existent registers.
// Ports:
//   clk       in   1         clock, all state on rising edge
//   rst       in   1         asynchronous active-high reset
//   wr_en     in   1         write request
//   dest      in   SEL_W     destination register code
//   din       in   DATA_W    write data
//   clr       in   1         synchronous bank clear, overrides any write
//   q0..q9    out  DATA_W    register contents (direct flop outputs)
//   valid     out  NUM_REGS  bit i = register i written since reset/clear
//   wr_ack    out  1         previous cycle's write was accepted
//   ack_dest  out  SEL_W     destination of last acknowledged write
//   bad_dest  out  1         sticky illegal-destination flag
module reg_dest_bank
  import reg_dest_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    dest,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
  output logic [DATA_W-1:0]   q0,
  output logic [DATA_W-1:0]   q1,
  output logic [DATA_W-1:0]   q2,
  output logic [DATA_W-1:0]   q3,
  output logic [DATA_W-1:0]   q4,
  output logic [DATA_W-1:0]   q5,
  output logic [DATA_W-1:0]   q6,
  output logic [DATA_W-1:0]   q7,
  output logic [DATA_W-1:0]   q8,
  output logic [DATA_W-1:0]   q9,
  output logic [NUM_REGS-1:0] valid,
  output logic                wr_ack,
  output logic [SEL_W-1:0]    ack_dest,
  output logic                bad_dest
);

  logic [NUM_REGS-1:0] dec_onehot;
  logic                dec_illegal;
  logic [NUM_REGS-1:0] reg_we;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q, valid_d;
  logic                ack_q, ack_d;
  reg_sel_t            ack_dest_q, ack_dest_d;
  logic                bad_q, bad_d;

  dest_decoder #(
    .NUM_REGS_P (NUM_REGS),
    .SEL_W_P    (SEL_W)
  ) u_dest_decoder (
    .en      (wr_en),
    .code    (dest),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  // Clear wins over a simultaneous write, so the enables are killed here.
  assign reg_we = dec_onehot & {NUM_REGS{~clr}};

  always_comb begin
    regs_d     = regs_q;
    valid_d    = valid_q;
    ack_d      = 1'b0;
    ack_dest_d = ack_dest_q;
    bad_d      = bad_q;
    if (clr) begin
      regs_d  = '{default: '0};
      valid_d = '0;
      bad_d   = 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) regs_d[i] = din;
      end
      valid_d = valid_q | reg_we;
      if (|reg_we) begin
        ack_d      = 1'b1;
        ack_dest_d = dest;
      end
      if (dec_illegal) bad_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      valid_q    <= '0;
      ack_q      <= 1'b0;
      ack_dest_q <= '0;
      bad_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      ack_dest_q <= ack_dest_d;
      bad_q      <= bad_d;
    end
  end

  assign q0       = regs_q[0];
  assign q1       = regs_q[1];
  assign q2       = regs_q[2];
  assign q3       = regs_q[3];
  assign q4       = regs_q[4];
  assign q5       = regs_q[5];
  assign q6       = regs_q[6];
  assign q7       = regs_q[7];
  assign q8       = regs_q[8];
  assign q9       = regs_q[9];
  assign valid    = valid_q;
  assign wr_ack   = ack_q;
  assign ack_dest = ack_dest_q;
  assign bad_dest = bad_q;

endmodule

// File: tb/tb_reg_dest_bank.sv
// tb/tb_reg_dest_bank.sv - self-checking bench for reg_dest_bank
module tb_reg_dest_bank;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] dest;
  logic [8:0] din;
  logic       clr;
  logic [8:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9;
  logic [9:0] valid;
  logic       wr_ack;
  logic [3:0] ack_dest;
  logic       bad_dest;

  logic [8:0] q_arr [10];
  assign q_arr[0] = q0; assign q_arr[1] = q1; assign q_arr[2] = q2;
  assign q_arr[3] = q3; assign q_arr[4] = q4; assign q_arr[5] = q5;
  assign q_arr[6] = q6; assign q_arr[7] = q7; assign q_arr[8] = q8;
  assign q_arr[9] = q9;

  int checks;
  int failures;

  // Reference state, kept as plain arrays and flags.
  logic [8:0] m_q [10];
  bit         m_written [10];
  bit         m_ack;
  int         m_ack_dest;
  bit         m_bad;

  reg_dest_bank dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .dest(dest), .din(din), .clr(clr),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .q5(q5), .q6(q6), .q7(q7), .q8(q8), .q9(q9),
    .valid(valid), .wr_ack(wr_ack), .ack_dest(ack_dest), .bad_dest(bad_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] m_valid_vec();
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = m_written[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_q[i] = 9'h000;
      m_written[i] = 0;
    end
    m_ack = 0;
    m_ack_dest = 0;
    m_bad = 0;
  endtask

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic cycle(input logic w, input logic [3:0] d, input logic [8:0] data, input logic c);
    wr_en = w; dest = d; din = data; clr = c;
    @(posedge clk);
    if (c) begin
      for (int i = 0; i < 10; i++) begin
        m_q[i] = 9'h000;
        m_written[i] = 0;
      end
      m_bad = 0;
      m_ack = 0;
    end else if (w) begin
      if (int'(d) < 10) begin
        m_q[d] = data;
        m_written[d] = 1;
        m_ack = 1;
        m_ack_dest = int'(d);
      end else begin
        m_ack = 0;
        m_bad = 1;
      end
    end else begin
      m_ack = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; dest = 4'd2; din = 9'h1FF; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q_arr[i] !== 9'h000) begin
        failures++;
        $display("FAIL reset_q%0d got=%h exp=000", i, q_arr[i]);
      end
    end
    checks++;
    if (valid !== 10'h000 || wr_ack !== 1'b0 || ack_dest !== 4'h0 || bad_dest !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%h ack=%b ack_dest=%h bad=%b exp 000/0/0/0",
               valid, wr_ack, ack_dest, bad_dest);
    end
    rst = 1'b0;
    cycle(1, 4'd5, 9'h1A5, 0);
    checks++;
    if (q5 !== 9'h1A5 || wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL first_write got q5=%h ack=%b exp q5=1a5 ack=1", q5, wr_ack);
    end
    cycle(1, 4'd12, 9'h033, 0);
    cycle(1, 4'd1, 9'h0F0, 0);
    // Asynchronous reset between edges must clear outputs immediately.
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (q5 !== 9'h000 || q1 !== 9'h000 || valid !== 10'h000 || wr_ack !== 1'b0 || bad_dest !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got q5=%h q1=%h valid=%h ack=%b bad=%b exp all zero",
               q5, q1, valid, wr_ack, bad_dest);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 4'(i), 9'(9'h100 + i), 0);
      checks++;
      if (q_arr[i] !== 9'(9'h100 + i) || wr_ack !== 1'b1 || ack_dest !== 4'(i)) begin
        failures++;
        $display("FAIL fill_%0d got q=%h ack=%b ack_dest=%0d exp q=%h ack=1 ack_dest=%0d",
                 i, q_arr[i], wr_ack, ack_dest, 9'(9'h100 + i), i);
      end
    end
    checks++;
    if (valid !== 10'h3FF) begin
      failures++;
      $display("FAIL fill_valid got=%h exp=3ff", valid);
    end
    cycle(0, 4'd0, 9'h000, 0);
    checks++;
    if (wr_ack !== 1'b0 || ack_dest !== 4'd9) begin
      failures++;
      $display("FAIL fill_idle got ack=%b ack_dest=%0d exp ack=0 ack_dest=9", wr_ack, ack_dest);
    end
  endtask

  task automatic test_illegal();
    cycle(1, 4'hA, 9'h055, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q_arr[i] !== 9'(9'h100 + i)) begin
        failures++;
        $display("FAIL illegal_q%0d got=%h exp=%h", i, q_arr[i], 9'(9'h100 + i));
      end
    end
    checks++;
    if (valid !== 10'h3FF || wr_ack !== 1'b0 || bad_dest !== 1'b1) begin
      failures++;
      $display("FAIL illegal_flags got valid=%h ack=%b bad=%b exp 3ff/0/1", valid, wr_ack, bad_dest);
    end
    cycle(1, 4'd2, 9'h0C3, 0);
    cycle(1, 4'hF, 9'h1FF, 0);
    cycle(1, 4'd4, 9'h13C, 0);
    checks++;
    if (bad_dest !== 1'b1 || q2 !== 9'h0C3 || q4 !== 9'h13C || wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL illegal_sticky got bad=%b q2=%h q4=%h ack=%b exp 1/0c3/13c/1",
               bad_dest, q2, q4, wr_ack);
    end
  endtask

  task automatic test_clear_priority();
    cycle(1, 4'd3, 9'h0AA, 1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q_arr[i] !== 9'h000) begin
        failures++;
        $display("FAIL clear_q%0d got=%h exp=000", i, q_arr[i]);
      end
    end
    checks++;
    if (valid !== 10'h000 || bad_dest !== 1'b0 || wr_ack !== 1'b0 || ack_dest !== 4'd4) begin
      failures++;
      $display("FAIL clear_flags got valid=%h bad=%b ack=%b ack_dest=%0d exp 000/0/0/4",
               valid, bad_dest, wr_ack, ack_dest);
    end
    cycle(1, 4'hB, 9'h011, 1);
    checks++;
    if (bad_dest !== 1'b0) begin
      failures++;
      $display("FAIL clear_over_illegal got bad=%b exp=0", bad_dest);
    end
  endtask

  task automatic test_overwrite();
    cycle(1, 4'd7, 9'h011, 0);
    checks++;
    if (q7 !== 9'h011 || wr_ack !== 1'b1) begin
      failures++;
      $display("FAIL overwrite_first got q7=%h ack=%b exp 011/1", q7, wr_ack);
    end
    cycle(1, 4'd7, 9'h122, 0);
    checks++;
    if (q7 !== 9'h122 || wr_ack !== 1'b1 || valid !== 10'h080 || ack_dest !== 4'd7) begin
      failures++;
      $display("FAIL overwrite_second got q7=%h ack=%b valid=%h ack_dest=%0d exp 122/1/080/7",
               q7, wr_ack, valid, ack_dest);
    end
  endtask

  task automatic test_idle_x();
    cycle(0, 4'bxxxx, 9'bx_xxxx_xxxx, 0);
    cycle(0, 4'bxxxx, 9'bx_xxxx_xxxx, 0);
    checks++;
    if (q7 !== 9'h122 || valid !== 10'h080 || wr_ack !== 1'b0 || bad_dest !== 1'b0 || ack_dest !== 4'd7) begin
      failures++;
      $display("FAIL idle_x got q7=%h valid=%h ack=%b bad=%b ack_dest=%h exp 122/080/0/0/7",
               q7, valid, wr_ack, bad_dest, ack_dest);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic       w, c;
      logic [3:0] d;
      logic [8:0] data;
      w    = ($urandom_range(0, 9) < 7);
      c    = ($urandom_range(0, 29) == 0);
      d    = 4'($urandom_range(0, 15));
      data = 9'($urandom);
      cycle(w, d, data, c);
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (q_arr[i] !== m_q[i]) begin
          failures++;
          $display("FAIL rand_q%0d iter=%0d got=%h exp=%h", i, n, q_arr[i], m_q[i]);
        end
      end
      checks++;
      if (valid !== m_valid_vec() || wr_ack !== m_ack || ack_dest !== 4'(m_ack_dest) || bad_dest !== m_bad) begin
        failures++;
        $display("FAIL rand_flags iter=%0d got valid=%h ack=%b ack_dest=%0d bad=%b exp %h/%b/%0d/%b",
                 n, valid, wr_ack, ack_dest, bad_dest, m_valid_vec(), m_ack, m_ack_dest, m_bad);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_illegal();
    test_clear_priority();
    test_overwrite();
    test_idle_x();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
